// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one 8N1 UART transmit line between two byte requesters.
//   Requesters are arbitrated round-robin in IDLE; the winning byte is sent
//   as start bit, 8 data bits LSB first, stop bit, each bit lasting
//   max(cfg_divider, DIV_MIN) clocks.
//
//   Optional build macro: UART_ARB_LOCK_EN
//     Adds req0_lock / req1_lock. A winner whose lock was high at its
//     handshake keeps exclusive ownership of later IDLE arbitrations for
//     as long as its lock stays high.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int DIV_WIDTH = 32,
    parameter int DIV_MIN   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] cfg_divider,
    input  logic                 req0_valid,
    input  logic [7:0]           req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [7:0]           req1_data,
    output logic                 req1_ready,
`ifdef UART_ARB_LOCK_EN
    input  logic                 req0_lock,
    input  logic                 req1_lock,
`endif
    output logic                 ser_tx,
    output logic                 busy,
    output logic                 grant_id
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_MIN_W = DIV_WIDTH'(DIV_MIN);
    localparam logic [DIV_WIDTH-1:0] ONE_W     = DIV_WIDTH'(1);
    localparam logic [3:0]           LAST_BIT  = 4'd9;

    state_t               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 grant_q, grant_d;
    logic [9:0]           shreg_q, shreg_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;

    logic                 sel_valid;
    logic                 sel_id;
    logic                 take;
    logic [7:0]           win_data;
    logic [DIV_WIDTH-1:0] eff_div;

`ifdef UART_ARB_LOCK_EN
    logic                 lock_held_q, lock_held_d;
    logic                 locked;
    logic                 win_lock;
`endif

    // Clamp the divider so a bit never lasts fewer than DIV_MIN clocks.
    assign eff_div = (cfg_divider < DIV_MIN_W) ? DIV_MIN_W : cfg_divider;

    // Round-robin selection among valid requesters, honouring an active lock.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        sel_valid = 1'b0;
        sel_id    = 1'b0;
`ifdef UART_ARB_LOCK_EN
        locked    = lock_held_q && (last_grant_q ? req1_lock : req0_lock);
        if (locked) begin
            sel_valid = last_grant_q ? req1_valid : req0_valid;
            sel_id    = last_grant_q;
        end else
`endif
        if (req0_valid && req1_valid) begin
            sel_valid = 1'b1;
            sel_id    = ~last_grant_q;
        end else if (req0_valid) begin
            sel_valid = 1'b1;
            sel_id    = 1'b0;
        end else if (req1_valid) begin
            sel_valid = 1'b1;
            sel_id    = 1'b1;
        end
    end

    // A byte is taken only in IDLE and never while reset is being sampled.
    assign take       = (state_q == IDLE) && !reset && sel_valid;
    assign req0_ready = take && !sel_id;
    assign req1_ready = take &&  sel_id;
    assign win_data   = sel_id ? req1_data : req0_data;
`ifdef UART_ARB_LOCK_EN
    assign win_lock   = sel_id ? req1_lock : req0_lock;
`endif

    // Next-state and datapath updates for the IDLE/SEND frame sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        shreg_d      = shreg_q;
        div_d        = div_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
`ifdef UART_ARB_LOCK_EN
        lock_held_d  = lock_held_q;
`endif
        case (state_q)
            IDLE: begin
                if (take) begin
                    shreg_d      = {1'b1, win_data, 1'b0};
                    div_d        = eff_div;
                    cnt_d        = eff_div - ONE_W;
                    bit_d        = 4'd0;
                    grant_d      = sel_id;
                    last_grant_d = sel_id;
`ifdef UART_ARB_LOCK_EN
                    lock_held_d  = win_lock;
`endif
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (cnt_q == '0) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = IDLE;
                    end else begin
                        shreg_d = {1'b1, shreg_q[9:1]};
                        bit_d   = bit_q + 4'd1;
                        cnt_d   = div_q - ONE_W;
                    end
                end else begin
                    cnt_d = cnt_q - ONE_W;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; an in-flight frame is abandoned.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            shreg_q      <= '1;
            div_q        <= DIV_MIN_W;
            cnt_q        <= '0;
            bit_q        <= 4'd0;
`ifdef UART_ARB_LOCK_EN
            lock_held_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            shreg_q      <= shreg_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
`ifdef UART_ARB_LOCK_EN
            lock_held_q  <= lock_held_d;
`endif
        end
    end

    assign ser_tx   = (state_q == SEND) ? shreg_q[0] : 1'b1;
    assign busy     = (state_q == SEND);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter: arbitration vector table,
//   directed frame/timing sequences with a serial line decoder, and a
//   randomized phase compared cycle by cycle against a frame-level model.
//   Build with +define+UART_ARB_LOCK_EN to exercise the lock feature.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cfg_divider = 32'd106;
    logic        req0_valid = 1'b0;
    logic [7:0]  req0_data = 8'h00;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [7:0]  req1_data = 8'h00;
    logic        req1_ready;
    logic        ser_tx;
    logic        busy;
    logic        grant_id;
`ifdef UART_ARB_LOCK_EN
    logic        req0_lock = 1'b0;
    logic        req1_lock = 1'b0;
`endif

    uart_tx_arbiter #(.DIV_WIDTH(32), .DIV_MIN(2)) dut (
        .clk(clk),
        .reset(reset),
        .cfg_divider(cfg_divider),
        .req0_valid(req0_valid),
        .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data(req1_data),
        .req1_ready(req1_ready),
`ifdef UART_ARB_LOCK_EN
        .req0_lock(req0_lock),
        .req1_lock(req1_lock),
`endif
        .ser_tx(ser_tx),
        .busy(busy),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Serial line decoder: samples mid-bit using the divider the test declares.
    bit          mon_en = 1'b1;
    int          line_div = 106;
    int          mon_st = 0;
    longint      mon_t0 = 0;
    longint      mon_off;
    longint      mon_k;
    logic [7:0]  mon_byte;
    int          rx_q[$];
    longint      rx_t[$];

    always @(negedge clk) begin
        if (reset || !mon_en) begin
            mon_st = 0;
        end else if (mon_st == 0) begin
            if (ser_tx === 1'b0) begin
                mon_st = 1;
                mon_t0 = cyc;
            end
        end else begin
            mon_off = cyc - mon_t0;
            if (mon_off % line_div == line_div / 2) begin
                mon_k = mon_off / line_div;
                if (mon_k >= 1 && mon_k <= 8) begin
                    mon_byte[mon_k - 1] = ser_tx;
                end else if (mon_k == 9) begin
                    rx_q.push_back(ser_tx ? int'(mon_byte) : (int'(mon_byte) | 256));
                    rx_t.push_back(mon_t0);
                    mon_st = 0;
                end
            end
        end
    end

    task automatic clear_rx();
        rx_q.delete();
        rx_t.delete();
    endtask

    task automatic check_rx(input string name, input int exp[8], input int n);
        check({name, "_count"}, rx_q.size(), n);
        for (int i = 0; i < n; i++)
            check(name, (i < rx_q.size()) ? rx_q[i] : -1, exp[i]);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
`ifdef UART_ARB_LOCK_EN
        req0_lock  = 1'b0;
        req1_lock  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Offer one byte and hold valid until accepted; returns just after the handshake edge.
    task automatic send(input bit id, input logic [7:0] d, output bit ok);
        ok = 1'b0;
        if (id) begin req1_valid = 1'b1; req1_data = d; end
        else    begin req0_valid = 1'b1; req0_data = d; end
        for (int i = 0; i < 3000; i++) begin
            #1;
            if ((id ? req1_ready : req0_ready) === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("send_accept", ok, 1);
    endtask

    // Count busy cycles until the frame ends, optionally changing the divider mid-frame.
    task automatic wait_idle(input int chg_at, input logic [31:0] chg_val, output int n);
        n = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n == chg_at) cfg_divider = chg_val;
        end
        @(posedge clk);
        #1;
    endtask

    // Two requesters each stream a list of bytes; requester 0 holds lock for its first lock0_n bytes.
    task automatic stream(input int b0[8], input int n0, input int s0,
                          input int b1[8], input int n1, input int s1,
                          input int lock0_n);
        int  i0 = 0;
        int  i1 = 0;
        bit  h0, h1;
        for (int c = 0; c < 12000; c++) begin
            if (i0 >= n0 && i1 >= n1) break;
            req0_valid = (c >= s0) && (i0 < n0);
            req0_data  = (i0 < n0) ? b0[i0][7:0] : 8'h00;
            req1_valid = (c >= s1) && (i1 < n1);
            req1_data  = (i1 < n1) ? b1[i1][7:0] : 8'h00;
`ifdef UART_ARB_LOCK_EN
            req0_lock  = (i0 < lock0_n);
`endif
            #1;
            h0 = req0_valid && req0_ready;
            h1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (h0) i0++;
            if (h1) i1++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
`ifdef UART_ARB_LOCK_EN
        req0_lock  = 1'b0;
`endif
        check("stream_all_accepted", i0 + i1, n0 + n1);
    endtask

    typedef struct {
        bit rst;
        bit v0;
        bit v1;
        bit e0;
        bit e1;
    } arb_vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        arb_vec_t   vecs[6];
        bit         ok;
        int         n, errs_bit, errs_busy;
        logic [9:0] frame;
        int         exp[8];
        logic [7:0] dat[2];
        bit         pend[2];
        int         gap[2];
        int         m_rem, m_d;
        bit         m_last, m_grant, m_lockh, lk, w;
        logic [9:0] m_frame;
        bit         e_r0, e_r1, e_busy, e_ser;

        vecs[0] = '{rst: 0, v0: 0, v1: 0, e0: 0, e1: 0};
        vecs[1] = '{rst: 0, v0: 1, v1: 0, e0: 1, e1: 0};
        vecs[2] = '{rst: 0, v0: 0, v1: 1, e0: 0, e1: 1};
        vecs[3] = '{rst: 0, v0: 1, v1: 1, e0: 1, e1: 0};
        vecs[4] = '{rst: 1, v0: 1, v1: 1, e0: 0, e1: 0};
        vecs[5] = '{rst: 1, v0: 0, v1: 1, e0: 0, e1: 0};

        // Reset state and single-cycle arbitration table (no handshake is let through).
        do_reset();
        check("reset_busy", busy, 0);
        check("reset_ser_tx", ser_tx, 1);
        check("reset_grant_id", grant_id, 0);
        for (int i = 0; i < 6; i++) begin
            reset      = vecs[i].rst;
            req0_valid = vecs[i].v0;
            req1_valid = vecs[i].v1;
            #1;
            check($sformatf("arb_vec%0d", i), {req0_ready, req1_ready}, {vecs[i].e0, vecs[i].e1});
            reset      = 1'b0;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            @(posedge clk);
            #1;
        end

        // 'U' at divider 106: bit-exact waveform and busy length.
        do_reset();
        cfg_divider = 32'd106;
        line_div    = 106;
        clear_rx();
        send(1'b0, 8'h55, ok);
        frame     = {1'b1, 8'h55, 1'b0};
        errs_bit  = 0;
        errs_busy = 0;
        for (int i = 0; i < 1060; i++) begin
            @(negedge clk);
            if (ser_tx !== frame[i / 106]) errs_bit++;
            if (busy !== 1'b1) errs_busy++;
        end
        check("u_waveform_errors", errs_bit, 0);
        check("u_busy_errors", errs_busy, 0);
        @(negedge clk);
        check("u_end_busy", busy, 0);
        check("u_end_ser_tx", ser_tx, 1);
        @(posedge clk);
        #1;
        exp = '{8'h55, 0, 0, 0, 0, 0, 0, 0};
        check_rx("u_rx", exp, 1);

        // Simultaneous requests: req0 first, req1 one frame later.
        do_reset();
        clear_rx();
        req0_valid = 1'b1; req0_data = 8'h41;
        req1_valid = 1'b1; req1_data = 8'h42;
        #1;
        check("contend_ready", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        check("contend_grant0", grant_id, 0);
        n = -1;
        for (int i = 0; i < 1200; i++) begin
            if (req1_ready === 1'b1) begin n = i; break; end
            @(posedge clk);
            #1;
        end
        check("contend_ready1_delay", n, 1060);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        check("contend_grant1", grant_id, 1);
        wait_idle(0, 32'd0, n);
        exp = '{8'h41, 8'h42, 0, 0, 0, 0, 0, 0};
        check_rx("contend_rx", exp, 2);
        check("contend_start_spacing", (rx_t.size() == 2) ? int'(rx_t[1] - rx_t[0]) : -1, 1061);

        // req1 streams '0'..'3'; req0 offers '~' during the first frame.
        do_reset();
        clear_rx();
        stream('{8'h7E, 0, 0, 0, 0, 0, 0, 0}, 1, 500,
               '{8'h30, 8'h31, 8'h32, 8'h33, 0, 0, 0, 0}, 4, 0, 0);
        wait_idle(0, 32'd0, n);
        exp = '{8'h30, 8'h7E, 8'h31, 8'h32, 8'h33, 0, 0, 0};
        check_rx("stream_rx", exp, 5);

        // Divider 0 clamps to 2; a mid-frame divider change waits for the next handshake.
        do_reset();
        cfg_divider = 32'd0;
        line_div    = 2;
        clear_rx();
        send(1'b0, 8'hA5, ok);
        wait_idle(5, 32'd106, n);
        check("div_clamp_frame_len", n, 20);
        line_div = 106;
        send(1'b1, 8'h5A, ok);
        wait_idle(0, 32'd0, n);
        check("div_next_frame_len", n, 1060);
        exp = '{8'hA5, 8'h5A, 0, 0, 0, 0, 0, 0};
        check_rx("div_rx", exp, 2);

        // Reset during data bit 4 aborts the frame; a later req1 byte goes out cleanly.
        do_reset();
        cfg_divider = 32'd106;
        line_div    = 106;
        clear_rx();
        send(1'b0, 8'h55, ok);
        repeat (5 * 106 + 50) @(negedge clk);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        req1_valid = 1'b1;
        req1_data  = 8'hC3;
        #1;
        check("abort_ready_in_reset", {req0_ready, req1_ready}, 2'b00);
        @(posedge clk);
        #1;
        check("abort_ser_tx", ser_tx, 1);
        check("abort_busy", busy, 0);
        check("abort_ready_after", {req0_ready, req1_ready}, 2'b00);
        reset = 1'b0;
        send(1'b1, 8'hC3, ok);
        check("abort_grant1", grant_id, 1);
        wait_idle(0, 32'd0, n);
        check("abort_new_frame_len", n, 1060);
        exp = '{8'hC3, 0, 0, 0, 0, 0, 0, 0};
        check_rx("abort_rx", exp, 1);

        // req0 (locked for its first three bytes when the lock feature exists) against req1.
        do_reset();
        cfg_divider = 32'd0;
        line_div    = 2;
        clear_rx();
        stream('{8'hA0, 8'hA1, 8'hA2, 8'hA3, 0, 0, 0, 0}, 4, 0,
               '{8'h99, 0, 0, 0, 0, 0, 0, 0}, 1, 0, 3);
        wait_idle(0, 32'd0, n);
`ifdef UART_ARB_LOCK_EN
        exp = '{8'hA0, 8'hA1, 8'hA2, 8'h99, 8'hA3, 0, 0, 0};
`else
        exp = '{8'hA0, 8'h99, 8'hA1, 8'hA2, 8'hA3, 0, 0, 0};
`endif
        check_rx("lock_rx", exp, 5);

        // Randomized traffic against a frame-level model (remaining-cycles counter).
        mon_en = 1'b0;
        do_reset();
        cfg_divider = 32'd1;
        m_rem   = 0;
        m_d     = 2;
        m_last  = 1'b1;
        m_grant = 1'b0;
        m_lockh = 1'b0;
        m_frame = '1;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 1'b0;
            gap[r]  = $urandom_range(0, 10);
            dat[r]  = 8'h00;
        end
        for (int cy = 0; cy < 3000; cy++) begin
            if ($urandom_range(0, 49) == 0) cfg_divider = $urandom_range(0, 4);
            for (int r = 0; r < 2; r++) begin
                if (!pend[r]) begin
                    if (gap[r] == 0) begin
                        pend[r] = 1'b1;
                        dat[r]  = 8'($urandom);
                    end else begin
                        gap[r]--;
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    pend[r] = 1'b0;
                    gap[r]  = $urandom_range(0, 30);
                end
            end
            req0_valid = pend[0];
            req0_data  = dat[0];
            req1_valid = pend[1];
            req1_data  = dat[1];
`ifdef UART_ARB_LOCK_EN
            if ($urandom_range(0, 19) == 0) req0_lock = ~req0_lock;
            if ($urandom_range(0, 19) == 0) req1_lock = ~req1_lock;
`endif
            #1;
            e_r0 = 1'b0;
            e_r1 = 1'b0;
            if (m_rem == 0) begin
                lk = 1'b0;
`ifdef UART_ARB_LOCK_EN
                lk = m_lockh && (m_last ? req1_lock : req0_lock);
`endif
                if (lk) begin
                    if (m_last) e_r1 = req1_valid;
                    else        e_r0 = req0_valid;
                end else if (req0_valid && req1_valid) begin
                    if (m_last) e_r0 = 1'b1;
                    else        e_r1 = 1'b1;
                end else begin
                    e_r0 = req0_valid;
                    e_r1 = req1_valid;
                end
            end
            e_busy = (m_rem != 0);
            e_ser  = (m_rem == 0) ? 1'b1 : m_frame[(10 * m_d - m_rem) / m_d];
            check("rand_cycle", {req0_ready, req1_ready, busy, ser_tx, grant_id},
                  {e_r0, e_r1, e_busy, e_ser, m_grant});
            @(posedge clk);
            #1;
            if (e_r0 || e_r1) begin
                w       = e_r1;
                m_frame = {1'b1, dat[w], 1'b0};
                m_d     = (cfg_divider < 2) ? 2 : int'(cfg_divider);
                m_rem   = 10 * m_d;
                m_grant = w;
                m_last  = w;
`ifdef UART_ARB_LOCK_EN
                m_lockh = w ? req1_lock : req0_lock;
`endif
                pend[w] = 1'b0;
                gap[w]  = $urandom_range(0, 20);
            end else if (m_rem > 0) begin
                m_rem--;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
